mbus_memory: RTL and testbench
==============================

Name: mbus_memory

Overview:
- Memory-side responder for the internal memory bus (iMBUS memory end), the counterpart of the MBOX initiator.
- Accepts quad-word read/write requests on two start lines (A, B), acknowledges, streams read data or absorbs write data in wrap-around word order, and checks and generates parity.
- Replaces the SBUS cable side of the MT01 translator with local storage.

Parameters:
- ADR_BITS, 14, implemented word-address bits; adr values at or above 2**ADR_BITS are nonexistent memory.
- RD_LAT, 3, clk cycles from ackn to first outValid (range 1..15).

Ports:
- clk  input  1  system clock
- reset  input  1  async active-high reset
- memReset  input  1  sync abort from MBOX
- diag  input  1  diagnostic mode: inverts generated parIn
- adrHold  input  1  blocks acceptance of new starts while high
- startA, startB  input  1 each  request strobes, held until matching ackn
- adr  input  22 [14:35]  word address
- adrPar  input  1  odd parity over adr
- rdRq, wrRq  input  1 each  read / write request (exactly one with start)
- rq  input  4 [0:3]  word mask within quad-word
- acknA, acknB  output  1 each  one-cycle acknowledge
- adrParErr  output  1  sticky address parity error
- error  output  1  sticky data parity / protocol error
- outValidA, outValidB  output  1 each  read word valid on dIn
- dIn  output  36 W36  read data to MBOX
- parIn  output  1  odd parity of dIn
- inValidA, inValidB  input  1 each  write word valid on dOut
- dOut  input  36 W36  write data from MBOX
- parOut  input  1  odd parity of dOut

Behaviour:
- Reset: every output is 0, FSM is IDLE, errors are clear. memReset does the same synchronously but preserves array contents.
- FSM states: IDLE, ACK, RDWAIT, RDXFER, WRXFER.
- IDLE: when adrHold=0 and startA|startB, A wins a tie. The block latches port, adr, rq, and rd/wr.
  - Address parity bad: set adrParErr, no ackn, stay IDLE.
  - adr out of range (NXM): no ackn, stay IDLE, ignore until start drops.
  - rdRq=wrRq (both or neither): set error, no ackn.
- ACK: assert the selected ackn for exactly 1 cycle.
  - rq=0000: return to IDLE.
  - Read: go to RDWAIT. Write: go to WRXFER.
- Word order: start at adr[34:35], increment mod 4 (wrap 3->0), visit only words whose rq bit is set. The physical address is {adr[14:33], idx}.
- RDWAIT: counts RD_LAT-1 cycles, then RDXFER.
- RDXFER: one masked word per cycle. outValidX=1 with dIn=array word and parIn=~^dIn (XOR with diag). After the last word, go to IDLE. outValid is 0 between transactions and dIn is 0 when not valid.
- WRXFER: on each inValidX cycle, write dOut to the current masked word and advance.
  - Parity mismatch: the word is still written, error is set.
  - Cycles without inValid hold the state; there is no timeout (MBOX owns the timeout).
- Start lines seen while busy are ignored. A start still high on return to IDLE is a new request.
- Sticky errors clear only on reset or memReset.
- memReset mid-transfer: abort immediately. Remaining words are not written and no further outValid is asserted.

Decomposition:
- Shared package holds: tMemState enum, W36 reuse, tQuadIdx (bit [0:1]), and a function for 36-bit odd parity.
- Sub-module mbus_mem_array: single-port synchronous RAM, 2**ADR_BITS x 36, registered read. It is instantiated once; RD_LAT counts from the address presented in ACK.

Test Plan:
- Write then read: startA, wrRq, adr=0o100, rq=1111, four inValidA words 1..4 with good parity -> acknA one cycle. Then read with rq=1111 -> outValidA starts RD_LAT cycles after ackn, dIn=1,2,3,4 consecutively, parIn correct.
- Wrap and mask: read adr=0o102, rq=1011 -> words delivered in order idx 2,3,0 (idx 1 skipped), three outValid pulses.
- Arbitration: startA and startB high in the same cycle -> acknA first; acknB follows after A completes with startB still held. adrHold=1 delays both acks.
- Error and NXM paths:
  - Bad adrPar -> adrParErr=1, no ackn.
  - adr=2**ADR_BITS -> no ackn ever.
  - Write with wrong parOut -> error=1 and the word is stored.
  - rdRq=wrRq=1 -> error=1, no ackn.
- Reset mid-operation: memReset during the 2nd read word -> no further outValid, FSM IDLE, error cleared. Async reset clears every output within the same cycle.

Source files
------------

// File: rtl/mbus_memory_pkg.sv
// Shared types for the iMBUS memory responder: FSM states, word type, quad index,
// and odd-parity helper.
package mbus_memory_pkg;

  typedef logic [35:0] W36;
  typedef bit [0:1] tQuadIdx;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RDWAIT,
    RDXFER,
    WRXFER
  } tMemState;

  function automatic logic odd_par36(input W36 d);
    return ~^d;
  endfunction

endpackage

// File: rtl/mbus_mem_array.sv
// Single-port synchronous word store with a registered read port; a write cycle
// returns the old contents on rdata.
module mbus_mem_array
  import mbus_memory_pkg::*;
#(
  parameter int ADR_BITS = 14
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADR_BITS-1:0] addr,
  input  W36                  wdata,
  output W36                  rdata
);

  W36 mem [2**ADR_BITS];
  W36 rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mbus_memory.sv
// iMBUS memory-end responder: accepts quad-word requests on start A/B, acknowledges,
// then streams read words or absorbs write words in wrap-around masked order.
module mbus_memory
  import mbus_memory_pkg::*;
#(
  parameter int ADR_BITS = 14,
  parameter int RD_LAT   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memReset,
  input  logic         diag,
  input  logic         adrHold,
  input  logic         startA,
  input  logic         startB,
  input  logic [14:35] adr,
  input  logic         adrPar,
  input  logic         rdRq,
  input  logic         wrRq,
  input  logic [0:3]   rq,
  output logic         acknA,
  output logic         acknB,
  output logic         adrParErr,
  output logic         error,
  output logic         outValidA,
  output logic         outValidB,
  output W36           dIn,
  output logic         parIn,
  input  logic         inValidA,
  input  logic         inValidB,
  input  W36           dOut,
  input  logic         parOut
);

  // First index at or after 'start' (mod 4) whose mask bit is set.
  function automatic tQuadIdx first_set(input tQuadIdx start, input logic [0:3] m);
    tQuadIdx r;
    logic    found;
    r     = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tQuadIdx i;
      i = start + tQuadIdx'(k);
      if (!found && m[i]) begin
        r     = i;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  tMemState            state_q, state_d;
  logic                port_q, port_d;
  logic [ADR_BITS-1:0] adr_q, adr_d;
  logic                rd_q, rd_d;
  logic [0:3]          rem_q, rem_d;
  tQuadIdx             idx_q, idx_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                par_err_q, par_err_d;
  logic                err_q, err_d;
  logic [1:0]          ign_q, ign_d;

  logic                req_a, req_b, p_sel, adr_par_ok, nxm, in_vld, we, out_vld;
  logic [0:3]          rem_nx;
  tQuadIdx             ram_idx;
  W36                  rdata;

  // A rejected start stays ignored until its line drops, so it cannot starve the other port.
  assign req_a      = startA & ~ign_q[0];
  assign req_b      = startB & ~ign_q[1];
  assign p_sel      = ~req_a;
  assign adr_par_ok = (^adr) ^ adrPar;
  assign nxm        = (adr >> ADR_BITS) != '0;
  assign in_vld     = port_q ? inValidB : inValidA;

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    adr_d     = adr_q;
    rd_d      = rd_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    par_err_d = par_err_q;
    err_d     = err_q;
    ign_d     = ign_q & {startB, startA};
    we        = 1'b0;
    rem_nx    = rem_q;
    rem_nx[idx_q] = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!adrHold && (req_a || req_b)) begin
          port_d = p_sel;
          adr_d  = adr[36-ADR_BITS:35];
          rd_d   = rdRq;
          rem_d  = rq;
          idx_d  = first_set(adr[34:35], rq);
          if (!adr_par_ok) begin
            par_err_d    = 1'b1;
            ign_d[p_sel] = 1'b1;
          end else if (nxm) begin
            ign_d[p_sel] = 1'b1;
          end else if (rdRq == wrRq) begin
            err_d        = 1'b1;
            ign_d[p_sel] = 1'b1;
          end else begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (rem_q == '0) state_d = IDLE;
        else if (!rd_q) state_d = WRXFER;
        else if (RD_LAT > 1) begin
          state_d = RDWAIT;
          cnt_d   = 4'(RD_LAT - 2);
        end else state_d = RDXFER;
      end
      RDWAIT: begin
        if (cnt_q == '0) state_d = RDXFER;
        else cnt_d = cnt_q - 4'd1;
      end
      RDXFER: begin
        rem_d = rem_nx;
        idx_d = first_set(tQuadIdx'(idx_q + 2'd1), rem_nx);
        if (rem_nx == '0) state_d = IDLE;
      end
      WRXFER: begin
        if (in_vld) begin
          we    = 1'b1;
          if (odd_par36(dOut) != parOut) err_d = 1'b1;
          rem_d = rem_nx;
          idx_d = first_set(tQuadIdx'(idx_q + 2'd1), rem_nx);
          if (rem_nx == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (memReset) begin
      state_d   = IDLE;
      par_err_d = 1'b0;
      err_d     = 1'b0;
      ign_d     = '0;
      we        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      adr_q     <= '0;
      rd_q      <= 1'b0;
      rem_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      par_err_q <= 1'b0;
      err_q     <= 1'b0;
      ign_q     <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      adr_q     <= adr_d;
      rd_q      <= rd_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      par_err_q <= par_err_d;
      err_q     <= err_d;
      ign_q     <= ign_d;
    end
  end

  // Read address runs one word ahead of dIn because the array read is registered.
  assign ram_idx = (state_q == WRXFER) ? idx_q : idx_d;

  mbus_mem_array #(.ADR_BITS(ADR_BITS)) u_array (
    .clk  (clk),
    .we   (we),
    .addr ({adr_q[ADR_BITS-1:2], ram_idx}),
    .wdata(dOut),
    .rdata(rdata)
  );

  assign acknA     = (state_q == ACK) & ~port_q;
  assign acknB     = (state_q == ACK) &  port_q;
  assign outValidA = (state_q == RDXFER) & ~port_q;
  assign outValidB = (state_q == RDXFER) &  port_q;
  assign out_vld   = outValidA | outValidB;
  assign dIn       = out_vld ? rdata : '0;
  assign parIn     = out_vld & (odd_par36(rdata) ^ diag);
  assign adrParErr = par_err_q;
  assign error     = err_q;

endmodule

// File: tb/tb_mbus_memory.sv
// Directed bench for mbus_memory: write/read, wrap+mask, arbitration, hold,
// error/NXM paths, memReset abort and async reset.
module tb_mbus_memory;
  import mbus_memory_pkg::*;

  localparam int ADR_BITS = 14;
  localparam int RD_LAT   = 3;

  logic         clk = 1'b0;
  logic         reset, memReset, diag, adrHold, startA, startB;
  logic [14:35] adr;
  logic         adrPar, rdRq, wrRq;
  logic [0:3]   rq;
  logic         acknA, acknB, adrParErr, error, outValidA, outValidB, parIn;
  W36           dIn;
  logic         inValidA, inValidB, parOut;
  W36           dOut;

  int   n_chk = 0;
  int   n_fail = 0;
  W36   rdq[$];
  logic parq[$];
  W36   ex[4];
  int   lat, cnt;

  always #5 clk = ~clk;

  mbus_memory #(.ADR_BITS(ADR_BITS), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .memReset(memReset), .diag(diag), .adrHold(adrHold),
    .startA(startA), .startB(startB), .adr(adr), .adrPar(adrPar), .rdRq(rdRq),
    .wrRq(wrRq), .rq(rq), .acknA(acknA), .acknB(acknB), .adrParErr(adrParErr),
    .error(error), .outValidA(outValidA), .outValidB(outValidB), .dIn(dIn),
    .parIn(parIn), .inValidA(inValidA), .inValidB(inValidB), .dOut(dOut),
    .parOut(parOut)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit b, input logic [21:0] a, input logic [3:0] m,
                     input bit rd, input bit wr, input bit bad);
    adr    = a;
    rq     = m;
    adrPar = (~^a) ^ bad;
    rdRq   = rd;
    wrRq   = wr;
    if (b) startB = 1'b1;
    else   startA = 1'b1;
  endtask

  task automatic drop;
    startA = 1'b0;
    startB = 1'b0;
    rdRq   = 1'b0;
    wrRq   = 1'b0;
  endtask

  // Returns the number of ticks until ackn of port b, or 0 if none within budget.
  task automatic wait_ack(input bit b, input int budget, output int l);
    l = 0;
    for (int i = 1; i <= budget && l == 0; i++) begin
      tick;
      if ((b ? acknB : acknA) === 1'b1) l = i;
    end
  endtask

  task automatic wr_word(input bit b, input W36 d, input bit bad);
    dOut   = d;
    parOut = (~^d) ^ bad;
    if (b) inValidB = 1'b1;
    else   inValidA = 1'b1;
    tick;
    inValidA = 1'b0;
    inValidB = 1'b0;
  endtask

  task automatic rd_collect(input bit b, output int l);
    int idle;
    idle = 0;
    l    = 0;
    rdq.delete();
    parq.delete();
    for (int i = 1; i <= 30 && idle < 2; i++) begin
      tick;
      if ((b ? outValidB : outValidA) === 1'b1) begin
        if (l == 0) l = i;
        rdq.push_back(dIn);
        parq.push_back(parIn);
      end else if (l != 0) idle++;
    end
  endtask

  task automatic chk_rd(input string tag, input int n, input bit dg);
    chk({tag, "_cnt"}, 64'(rdq.size()), 64'(n));
    for (int i = 0; i < n && i < rdq.size(); i++) begin
      chk({tag, "_d"}, rdq[i], ex[i]);
      chk({tag, "_p"}, parq[i], (~^ex[i]) ^ dg);
    end
    chk({tag, "_dIn0"}, dIn, 0);
  endtask

  task automatic mem_reset;
    memReset = 1'b1;
    tick;
    memReset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; memReset = 1'b0; diag = 1'b0; adrHold = 1'b0;
    startA = 1'b0; startB = 1'b0; adr = '0; adrPar = 1'b0; rdRq = 1'b0; wrRq = 1'b0;
    rq = '0; inValidA = 1'b0; inValidB = 1'b0; dOut = '0; parOut = 1'b0;
    tick; tick;
    chk("rst_ackn", {acknA, acknB}, 0);
    chk("rst_valid", {outValidA, outValidB}, 0);
    chk("rst_dIn", dIn, 0);
    chk("rst_err", {adrParErr, error, parIn}, 0);
    reset = 1'b0;
    tick;

    // Write words 1..4 to 0o100
    req(0, 22'o100, 4'b1111, 0, 1, 0);
    wait_ack(0, 5, lat);
    chk("wr_ack_lat", lat, 1);
    chk("wr_acknB", acknB, 0);
    drop;
    tick;
    chk("wr_ack_one", acknA, 0);
    for (int i = 1; i <= 4; i++) wr_word(0, W36'(i), 0);
    chk("wr_err", error, 0);

    // Read back
    req(0, 22'o100, 4'b1111, 1, 0, 0);
    wait_ack(0, 5, lat);
    chk("rd_ack_lat", lat, 1);
    drop;
    rd_collect(0, lat);
    chk("rd_lat", lat, RD_LAT);
    ex = '{36'd1, 36'd2, 36'd3, 36'd4};
    chk_rd("rd_seq", 4, 0);

    // Wrap and mask with diag parity inversion: idx 2,3,0
    diag = 1'b1;
    req(0, 22'o102, 4'b1011, 1, 0, 0);
    wait_ack(0, 5, lat);
    drop;
    rd_collect(0, lat);
    ex = '{36'd3, 36'd4, 36'd1, 36'd0};
    chk_rd("wrap", 3, 1);
    diag = 1'b0;

    // Arbitration: tie goes to A, B served after A completes
    req(0, 22'o100, 4'b0100, 1, 0, 0);
    startB = 1'b1;
    wait_ack(0, 5, lat);
    chk("arb_ackA", lat, 1);
    chk("arb_noB", acknB, 0);
    startA = 1'b0;
    wait_ack(1, 12, lat);
    chk("arb_ackB_lat", lat, RD_LAT + 2);
    chk("arb_ackA_off", acknA, 0);
    drop;
    rd_collect(1, lat);
    chk("arb_B_lat", lat, RD_LAT);
    ex = '{36'd2, 36'd0, 36'd0, 36'd0};
    chk_rd("arb_B", 1, 0);

    // adrHold blocks acceptance
    adrHold = 1'b1;
    req(0, 22'o100, 4'b0001, 1, 0, 0);
    wait_ack(0, 6, lat);
    chk("hold_noack", lat, 0);
    adrHold = 1'b0;
    wait_ack(0, 3, lat);
    chk("hold_release", lat, 1);
    drop;
    rd_collect(0, lat);
    ex = '{36'd4, 36'd0, 36'd0, 36'd0};
    chk_rd("hold_rd", 1, 0);

    // Bad address parity
    req(0, 22'o100, 4'b1111, 1, 0, 1);
    wait_ack(0, 5, lat);
    chk("apar_noack", lat, 0);
    chk("apar_err", adrParErr, 1);
    drop;
    tick;
    chk("apar_sticky", adrParErr, 1);
    mem_reset;
    chk("apar_clr", adrParErr, 0);

    // Nonexistent memory
    req(0, 22'h1 << ADR_BITS, 4'b1111, 1, 0, 0);
    wait_ack(0, 10, lat);
    chk("nxm_noack", lat, 0);
    chk("nxm_noerr", {adrParErr, error}, 0);
    drop;
    tick;

    // Write with bad data parity still stores the word
    req(0, 22'o200, 4'b0001, 0, 1, 0);
    wait_ack(0, 5, lat);
    chk("dpar_ack", lat, 1);
    drop;
    tick;
    wr_word(0, 36'h123456789, 1);
    chk("dpar_err", error, 1);
    req(0, 22'o200, 4'b0001, 1, 0, 0);
    wait_ack(0, 5, lat);
    drop;
    rd_collect(0, lat);
    ex = '{36'h123456789, 36'd0, 36'd0, 36'd0};
    chk_rd("dpar_rd", 1, 0);
    chk("dpar_sticky", error, 1);
    mem_reset;
    chk("err_clr", error, 0);

    // rdRq = wrRq
    req(0, 22'o100, 4'b1111, 1, 1, 0);
    wait_ack(0, 5, lat);
    chk("proto_noack", lat, 0);
    chk("proto_err", error, 1);
    drop;
    tick;

    // memReset during the 2nd read word aborts the transfer
    req(0, 22'o100, 4'b1111, 1, 0, 0);
    wait_ack(0, 5, lat);
    chk("abort_ack", lat, 1);
    drop;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      tick;
      if (outValidA === 1'b1) cnt++;
    end
    chk("abort_2nd", cnt, 2);
    chk("abort_2nd_d", dIn, 2);
    mem_reset;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (outValidA !== 1'b0) cnt++;
      tick;
    end
    chk("abort_novalid", cnt, 0);
    chk("abort_errclr", error, 0);

    // Async reset clears outputs without a clock edge
    req(0, 22'o100, 4'b1111, 1, 0, 0);
    wait_ack(0, 5, lat);
    chk("ares_ack", lat, 1);
    drop;
    cnt = 0;
    for (int i = 0; i < 10 && cnt == 0; i++) begin
      tick;
      if (outValidA === 1'b1) cnt = 1;
    end
    chk("ares_valid", cnt, 1);
    #2 reset = 1'b1;
    #1;
    chk("ares_valid0", {outValidA, outValidB, acknA, acknB}, 0);
    chk("ares_dIn0", {dIn, parIn}, 0);
    chk("ares_err0", {adrParErr, error}, 0);
    #1 reset = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
